samp_window_ctrl: RTL and testbench

//  Sequencer for the 3-column sample shift register (36-bit sample = 3 x 12-bit columns).

---
 rtl/samp_window_ctrl.sv | 114 +++++++++++
 tb/tb_samp_window_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/samp_window_ctrl.sv
// Sequencer for the 3-column sample shift register: scans the image in 3-row bands,
// fetches one column word per step and flags when a full 3x3 window is ready.
module samp_window_ctrl #(
  parameter int unsigned IMG_W  = 16,
  parameter int unsigned IMG_H  = 16,
  parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  output logic              shift_en,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [7:0]        win_x,
  output logic [7:0]        win_y
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 3) ? $clog2(IMG_H - 2) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StEmit, StDone} state_e;

  state_e        state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [1:0]    fill_q;
  logic [1:0]    fill_nxt;
  logic          x_last;
  logic          y_last;

  assign fill_nxt = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
  assign x_last   = (x_q == XW'(IMG_W - 1));
  assign y_last   = (y_q == YW'(IMG_H - 3));
  assign shift_en = rd_req & rd_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      fill_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFetch;
            busy    <= 1'b1;
            rd_req  <= 1'b1;
            rd_addr <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fill_q  <= '0;
          end
        end
        StFetch: begin
          if (rd_ack) begin
            fill_q <= fill_nxt;
            if (fill_nxt == 2'd3) begin
              state_q   <= StEmit;
              rd_req    <= 1'b0;
              win_valid <= 1'b1;
              win_x     <= 8'(x_q) - 8'd2;
              win_y     <= 8'(y_q);
            end else begin
              x_q     <= x_q + XW'(1);
              rd_addr <= rd_addr + ADDR_W'(1);
            end
          end
        end
        StEmit: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (!x_last) begin
              state_q <= StFetch;
              rd_req  <= 1'b1;
              x_q     <= x_q + XW'(1);
              rd_addr <= rd_addr + ADDR_W'(1);
            end else if (!y_last) begin
              // Row wrap: y*W + (W-1) + 1 == (y+1)*W, so the address still just increments.
              state_q <= StFetch;
              rd_req  <= 1'b1;
              x_q     <= '0;
              y_q     <= y_q + YW'(1);
              fill_q  <= '0;
              rd_addr <= rd_addr + ADDR_W'(1);
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_samp_window_ctrl.sv
// Bench for samp_window_ctrl: a 4x3 instance driven from a vector table and a 4x4 instance
// driven by hand-written corner sequences and randomized scans checked against an event model.
module tb_samp_window_ctrl;

  localparam int unsigned A_W = 4;
  localparam int unsigned A_H = 3;
  localparam int unsigned B_W = 4;
  localparam int unsigned B_H = 4;
  localparam int unsigned AW_A = $clog2(A_W * A_H);
  localparam int unsigned AW_B = $clog2(B_W * B_H);

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic rst;

  logic            a_start, a_rd_ack, a_win_ready;
  logic            a_busy, a_done, a_rd_req, a_shift_en, a_win_valid;
  logic [AW_A-1:0] a_rd_addr;
  logic [7:0]      a_win_x, a_win_y;

  logic            b_start, b_rd_ack, b_win_ready;
  logic            b_busy, b_done, b_rd_req, b_shift_en, b_win_valid;
  logic [AW_B-1:0] b_rd_addr;
  logic [7:0]      b_win_x, b_win_y;

  samp_window_ctrl #(.IMG_W(A_W), .IMG_H(A_H), .ADDR_W(AW_A)) u_a (
    .clk       (tb_clk),
    .rst       (rst),
    .start     (a_start),
    .busy      (a_busy),
    .done      (a_done),
    .rd_req    (a_rd_req),
    .rd_addr   (a_rd_addr),
    .rd_ack    (a_rd_ack),
    .shift_en  (a_shift_en),
    .win_valid (a_win_valid),
    .win_ready (a_win_ready),
    .win_x     (a_win_x),
    .win_y     (a_win_y)
  );

  samp_window_ctrl #(.IMG_W(B_W), .IMG_H(B_H), .ADDR_W(AW_B)) u_b (
    .clk       (tb_clk),
    .rst       (rst),
    .start     (b_start),
    .busy      (b_busy),
    .done      (b_done),
    .rd_req    (b_rd_req),
    .rd_addr   (b_rd_addr),
    .rd_ack    (b_rd_ack),
    .shift_en  (b_shift_en),
    .win_valid (b_win_valid),
    .win_ready (b_win_ready),
    .win_x     (b_win_x),
    .win_y     (b_win_y)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
    end
  endtask

  typedef struct {
    logic       start;
    logic       ack;
    logic       ready;
    logic       busy;
    logic       done;
    logic       rd_req;
    logic [3:0] addr;
    logic       shift_en;
    logic       wv;
    logic [7:0] wx;
    logic [7:0] wy;
  } vec_t;

  vec_t tbl[10];

  // Expected handshake events: fetch = 1<<24|addr, window = 2<<24|x<<8|y, done = 3<<24.
  int unsigned exp_q[$];

  task automatic observe(input string name, input int unsigned obs);
    int unsigned expv;
    expv = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hffff_ffff;
    chk(name, 64'(obs), 64'(expv));
  endtask

  task automatic run_scan(input int unsigned ack_pct, input int unsigned rdy_pct);
    bit seen;
    int cyc;
    int dones;
    exp_q.delete();
    for (int y = 0; y <= int'(B_H) - 3; y++) begin
      for (int x = 0; x < int'(B_W); x++) begin
        exp_q.push_back((32'd1 << 24) | 32'(y * int'(B_W) + x));
        if (x >= 2) exp_q.push_back((32'd2 << 24) | (32'(x - 2) << 8) | 32'(y));
      end
    end
    exp_q.push_back(32'd3 << 24);

    @(negedge tb_clk);
    b_start = 1'b1; b_rd_ack = 1'b0; b_win_ready = 1'b0;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 3000) begin
      @(negedge tb_clk);
      cyc++;
      b_rd_ack    = ($urandom_range(0, 99) < ack_pct);
      b_win_ready = ($urandom_range(0, 99) < rdy_pct);
      b_start     = ($urandom_range(0, 7) == 0);
      #1;
      if (b_rd_req && b_rd_ack) observe("scan fetch", (32'd1 << 24) | 32'(b_rd_addr));
      if (b_win_valid && b_win_ready)
        observe("scan window", (32'd2 << 24) | (32'(b_win_x) << 8) | 32'(b_win_y));
      if (b_done) begin
        observe("scan done", 32'd3 << 24);
        seen = 1'b1;
      end
    end
    b_start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL scan timeout: done not seen after %0d cycles, required within 3000", cyc);
    end
    @(negedge tb_clk);
    #1 chk("scan idle after done", {b_busy, b_done, b_rd_req, b_win_valid}, 0);
    chk("scan events left", 64'(exp_q.size()), 0);
    dones = 0;
    repeat (4) begin
      @(negedge tb_clk);
      #1 dones += int'(b_done);
    end
    chk("scan extra done", 64'(dones), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_rd_ack = 1'b0; a_win_ready = 1'b0;
    b_start = 1'b0; b_rd_ack = 1'b0; b_win_ready = 1'b0;

    // 4x3 zero-wait scan; last start pulse lands in the done cycle and must be ignored.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 8'd0, 8'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 8'd0, 8'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 8'd0, 8'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 8'd0, 8'd0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 8'd0, 8'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 8'd1, 8'd0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 8'd0};

    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    rst = 1'b0;
    #1;
    chk("reset a", {a_busy, a_done, a_rd_req, a_shift_en, a_win_valid, a_rd_addr, a_win_x, a_win_y},
        0);
    chk("reset b", {b_busy, b_done, b_rd_req, b_shift_en, b_win_valid, b_rd_addr, b_win_x, b_win_y},
        0);

    for (int i = 0; i < 10; i++) begin
      @(negedge tb_clk);
      a_start = tbl[i].start; a_rd_ack = tbl[i].ack; a_win_ready = tbl[i].ready;
      #1;
      chk($sformatf("vec%0d", i),
          {a_busy, a_done, a_rd_req, a_shift_en, a_win_valid,
           (tbl[i].rd_req ? a_rd_addr : 4'd0), (tbl[i].wv ? {a_win_x, a_win_y} : 16'd0)},
          {tbl[i].busy, tbl[i].done, tbl[i].rd_req, tbl[i].shift_en, tbl[i].wv,
           tbl[i].addr, (tbl[i].wv ? {tbl[i].wx, tbl[i].wy} : 16'd0)});
    end
    a_start = 1'b0; a_rd_ack = 1'b0; a_win_ready = 1'b0;

    // Memory stall during fetch of x=1.
    @(negedge tb_clk);
    b_start = 1'b1; b_rd_ack = 1'b0; b_win_ready = 1'b0;
    @(negedge tb_clk);
    b_start = 1'b0; b_rd_ack = 1'b1;
    #1 chk("stall first fetch", {b_rd_req, b_shift_en, b_rd_addr}, {2'b11, 4'd0});
    @(negedge tb_clk);
    b_rd_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall hold", {b_rd_req, b_shift_en, b_win_valid, b_rd_addr}, {3'b100, 4'd1});
      @(negedge tb_clk);
    end
    b_rd_ack = 1'b1;
    #1 chk("stall resume", {b_rd_req, b_shift_en, b_rd_addr}, {2'b11, 4'd1});
    @(negedge tb_clk);
    #1 chk("stall third fetch", {b_rd_req, b_shift_en, b_win_valid, b_rd_addr}, {3'b110, 4'd2});

    // Backpressure at window (0,0); rd_ack high here must be ignored.
    @(negedge tb_clk);
    b_win_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("backpressure hold", {b_win_valid, b_rd_req, b_shift_en, b_win_x, b_win_y},
             {3'b100, 8'd0, 8'd0});
      @(negedge tb_clk);
    end
    b_win_ready = 1'b1;
    #1 chk("backpressure accept", {b_win_valid, b_win_x, b_win_y}, {1'b1, 8'd0, 8'd0});
    @(negedge tb_clk);
    b_win_ready = 1'b0; b_rd_ack = 1'b0;
    #1 chk("fetch after accept", {b_rd_req, b_win_valid, b_rd_addr}, {2'b10, 4'd3});

    // start while busy must not restart the scan.
    b_start = 1'b1;
    @(negedge tb_clk);
    b_start = 1'b0;
    #1 chk("start while busy", {b_busy, b_rd_req, b_rd_addr}, {2'b11, 4'd3});
    b_rd_ack = 1'b1;
    @(negedge tb_clk);
    b_rd_ack = 1'b0;
    #1 chk("saturated fill window", {b_win_valid, b_win_x, b_win_y}, {1'b1, 8'd1, 8'd0});

    // Reset mid-scan aborts without a done pulse.
    rst = 1'b1;
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    rst = 1'b0; b_rd_ack = 1'b1; b_win_ready = 1'b1;
    #1 chk("midscan reset", {b_busy, b_done, b_rd_req, b_shift_en, b_win_valid, b_rd_addr}, 0);
    begin
      int dn;
      dn = 0;
      repeat (4) begin
        @(negedge tb_clk);
        #1 dn += int'(b_done) + int'(b_busy);
      end
      chk("no activity after reset", 64'(dn), 0);
    end
    b_rd_ack = 1'b0; b_win_ready = 1'b0;

    // Full 4x4 scans (covers the row wrap) under varying memory/backpressure behaviour.
    run_scan(100, 100);
    run_scan(60, 50);
    run_scan(30, 70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
